aludec_seq: RTL

- Parametrised successor to the CPU's ALU control decoder.
- Decodes aluop/funct into the 4-bit ALU control word for single-cycle ops.
- Also owns an iterative multiply/divide sequencer for multi-cycle funct codes, with a start/ready/done handshake.
- Sits between the main control unit and the datapath ALU; busy stalls the pipeline.

---
 rtl/aludec_pkg.sv | 30 +++
 rtl/aludec_seq_muldiv_iter.sv | 68 ++++++
 rtl/aludec_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/aludec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aludec_pkg
// Description : Shared encodings for the ALU control decoder and its
//               iterative multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package aludec_pkg;

  localparam logic [3:0] ALU_NOP   = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;

  // funct codes 0001..0111 pass straight through as ALU control words
  localparam logic [3:0] F_PASS_LO = 4'b0001;
  localparam logic [3:0] F_PASS_HI = 4'b0111;
  localparam logic [3:0] F_MULU    = 4'b1000;
  localparam logic [3:0] F_DIVU    = 4'b1001;
  localparam logic [3:0] F_MULS    = 4'b1010;
  localparam logic [3:0] F_DIVS    = 4'b1011;

  localparam logic [1:0] AOP_FUNCT = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_ADD   = 2'b10;
  localparam logic [1:0] AOP_NOP   = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIN} seq_state_t;

endpackage
`default_nettype wire

// File: rtl/aludec_seq_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : One-bit-per-cycle shift-add multiplier / restoring divider
//               datapath; sequencing is owned by aludec_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
  parameter  int N  = 32,
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          step,
  input  logic          op_div,
  input  logic [N-1:0]  opa,
  input  logic [N-1:0]  opb,
  output logic [CW-1:0] cnt,
  output logic [N-1:0]  nxt_hi,
  output logic [N-1:0]  nxt_lo
);

  logic [N-1:0]  r_hi;
  logic [N-1:0]  r_lo;
  logic [N-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic [N:0]    w_sum;
  logic [N:0]    w_sh;
  logic [N:0]    w_diff;

  // r_hi is the product accumulator or partial remainder; r_lo holds the
  // multiplier or the dividend shifting out while quotient bits shift in.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_sh   = {r_hi, r_lo[N-1]};
    w_diff = w_sh - {1'b0, r_b};
    if (op_div) begin
      nxt_hi = w_diff[N] ? w_sh[N-1:0] : w_diff[N-1:0];
      nxt_lo = {r_lo[N-2:0], ~w_diff[N]};
    end else begin
      nxt_hi = w_sum[N:1];
      nxt_lo = {w_sum[0], r_lo[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_hi  <= '0;
      r_lo  <= opa;
      r_b   <= opb;
      r_cnt <= CW'(N);
    end else if (step) begin
      r_hi  <= nxt_hi;
      r_lo  <= nxt_lo;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/aludec_seq.sv
`default_nettype none
// ============================================================================
// Module      : aludec_seq
// Description : ALU control decoder with an iterative mul/div sequencer.
//               Define ALUDEC_SIGNED_MULDIV_EN to add signed MUL/DIV.
// Revision    : 1.0 - initial release
// ============================================================================
module aludec_seq
  import aludec_pkg::*;
#(
  parameter int N  = 32,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          valid,
  input  logic          kill,
  input  logic [1:0]    aluop,
  input  logic [FW-1:0] funct,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic [3:0]    aluctrl,
  output logic          illegal,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result_lo,
  output logic [N-1:0]  result_hi,
  output logic          dbz
);

  localparam int CW = $clog2(N) + 1;

  seq_state_t     r_state;
  seq_state_t     w_next;
  logic           w_md;
  logic           w_md_div;
  logic           w_start;
  logic           w_dbz_start;
  logic           w_load;
  logic           w_step;
  logic           w_fin_run;
  logic           r_div;
  logic [N-1:0]   w_opa;
  logic [N-1:0]   w_opb;
  logic [CW-1:0]  w_cnt;
  logic [N-1:0]   w_nxt_hi;
  logic [N-1:0]   w_nxt_lo;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_quo;
  logic [N-1:0]   w_rem;
  logic [N-1:0]   w_res_hi;
  logic [N-1:0]   w_res_lo;
  logic [N-1:0]   r_res_hi;
  logic [N-1:0]   r_res_lo;
  logic           r_dbz;
`ifdef ALUDEC_SIGNED_MULDIV_EN
  logic           w_md_sgn;
  logic           r_sgn;
  logic           r_negq;
  logic           r_negr;
`endif

  always_comb begin
    aluctrl  = ALU_NOP;
    illegal  = 1'b0;
    w_md     = 1'b0;
    w_md_div = 1'b0;
`ifdef ALUDEC_SIGNED_MULDIV_EN
    w_md_sgn = 1'b0;
`endif
    case (aluop)
      AOP_SUB: aluctrl = ALU_SUB;
      AOP_ADD: aluctrl = ALU_ADD;
      AOP_NOP: aluctrl = ALU_NOP;
      default: begin
        if (funct >= FW'(F_PASS_LO) && funct <= FW'(F_PASS_HI)) begin
          aluctrl = funct[3:0];
        end else if (funct == FW'(F_MULU)) begin
          w_md = 1'b1;
        end else if (funct == FW'(F_DIVU)) begin
          w_md     = 1'b1;
          w_md_div = 1'b1;
`ifdef ALUDEC_SIGNED_MULDIV_EN
        end else if (funct == FW'(F_MULS)) begin
          w_md     = 1'b1;
          w_md_sgn = 1'b1;
        end else if (funct == FW'(F_DIVS)) begin
          w_md     = 1'b1;
          w_md_div = 1'b1;
          w_md_sgn = 1'b1;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
    endcase
  end

  // kill beats a coincident issue so an aborted slot never starts
  assign w_start     = valid & ready & ~kill & w_md;
  assign w_dbz_start = w_start & w_md_div & (b == '0);

`ifdef ALUDEC_SIGNED_MULDIV_EN
  assign w_opa = (w_md_sgn && a[N-1]) ? -a : a;
  assign w_opb = (w_md_sgn && b[N-1]) ? -b : b;
`else
  assign w_opa = a;
  assign w_opb = b;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_fin_run = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dbz_start) begin
          w_next = FIN;
        end else if (w_start) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        if (kill) begin
          w_next = IDLE;
        end else begin
          w_step = 1'b1;
          if (w_cnt == CW'(1)) begin
            w_next    = FIN;
            w_fin_run = 1'b1;
          end
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= 1'b0;
`ifdef ALUDEC_SIGNED_MULDIV_EN
      r_sgn  <= 1'b0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
`endif
    end else if (w_load) begin
      r_div  <= w_md_div;
`ifdef ALUDEC_SIGNED_MULDIV_EN
      r_sgn  <= w_md_sgn;
      r_negq <= a[N-1] ^ b[N-1];
      r_negr <= a[N-1];
`endif
    end
  end

  muldiv_iter #(.N(N)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_load),
    .step    (w_step),
    .op_div  (r_div),
    .opa     (w_opa),
    .opb     (w_opb),
    .cnt     (w_cnt),
    .nxt_hi  (w_nxt_hi),
    .nxt_lo  (w_nxt_lo)
  );

  // Results are captured from the final iteration's next-state values so
  // they are already correct (sign-fixed) during the done cycle.
  always_comb begin
    w_prod = {w_nxt_hi, w_nxt_lo};
    w_quo  = w_nxt_lo;
    w_rem  = w_nxt_hi;
`ifdef ALUDEC_SIGNED_MULDIV_EN
    if (r_sgn && r_negq) begin
      w_prod = -w_prod;
      w_quo  = -w_quo;
    end
    if (r_sgn && r_negr) begin
      w_rem = -w_rem;
    end
`endif
    if (r_div) begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end else begin
      w_res_hi = w_prod[2*N-1:N];
      w_res_lo = w_prod[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_dbz    <= 1'b0;
    end else if (w_dbz_start) begin
      r_res_lo <= '1;
      r_res_hi <= a;
      r_dbz    <= 1'b1;
    end else if (w_fin_run) begin
      r_res_lo <= w_res_lo;
      r_res_hi <= w_res_hi;
      r_dbz    <= 1'b0;
    end
  end

  assign ready     = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign done      = (r_state == FIN);
  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;
  assign dbz       = r_dbz;

endmodule
`default_nettype wire
